// File: rtl/operand_stage.sv
// Registered source-operand selector between decode and execute. It forwards PB from
// EX/MEM and picks the second operand N. A 2-entry skid buffer (OUT + SKID) sits behind a
// valid/ready output, and a saturating counter tracks slots that used the reserved selector.
module operand_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       si,
  input  logic [W-1:0]     pb,
  input  logic [W-1:0]     hi,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     pc,
  input  logic [IMM_W-1:0] imm,
  input  logic [4:0]       rt_addr,
  input  logic             fwd_ex_en,
  input  logic [4:0]       fwd_ex_addr,
  input  logic [W-1:0]     fwd_ex_data,
  input  logic             fwd_mem_en,
  input  logic [4:0]       fwd_mem_addr,
  input  logic [W-1:0]     fwd_mem_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     n,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [2:0] SelPb   = 3'b000;
  localparam logic [2:0] SelHi   = 3'b001;
  localparam logic [2:0] SelLo   = 3'b010;
  localparam logic [2:0] SelPc8  = 3'b011;
  localparam logic [2:0] SelSext = 3'b100;
  localparam logic [2:0] SelZext = 3'b101;
  localparam logic [2:0] SelUpper = 3'b110;

  logic [W-1:0] n_q, n_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         skid_err_q, skid_err_d;
  logic         skid_full_q, skid_full_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  logic [W-1:0] pbf;
  logic [W-1:0] imm_zx;
  logic [W-1:0] result;
  logic         result_err;
  logic         accept;
  logic         out_fire;
  logic         out_free;

  assign imm_zx   = {{(W-IMM_W){1'b0}}, imm};
  assign in_ready = !skid_full_q;
  assign accept   = in_valid && in_ready && !flush;
  assign out_fire = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_fire;

  // Forwarded PB: register 0 is hardwired to zero, and EX wins over MEM.
  always_comb begin
    pbf = pb;
    if (rt_addr == 5'd0) begin
      pbf = '0;
    end else if (fwd_ex_en && (fwd_ex_addr == rt_addr)) begin
      pbf = fwd_ex_data;
    end else if (fwd_mem_en && (fwd_mem_addr == rt_addr)) begin
      pbf = fwd_mem_data;
    end
  end

  // Operand select; the reserved code yields zero and flags the slot.
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (si)
      SelPb:    result = pbf;
      SelHi:    result = hi;
      SelLo:    result = lo;
      SelPc8:   result = pc + W'(8);
      SelSext:  result = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
      SelZext:  result = imm_zx;
      SelUpper: result = imm_zx << IMM_W;
      default:  result_err = 1'b1;
    endcase
  end

  // Skid-buffer next state: SKID always drains into OUT before any new slot, keeping FIFO order.
  always_comb begin
    n_d         = n_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        n_d         = skid_data_q;
        err_d       = skid_err_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
        if (accept) begin
          skid_data_d = result;
          skid_err_d  = result_err;
          skid_full_d = 1'b1;
        end
      end else if (accept) begin
        n_d         = result;
        err_d       = result_err;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d = result;
      skid_err_d  = result_err;
      skid_full_d = 1'b1;
    end
  end

  // Saturating count of accepted reserved-code slots (accept already excludes flushed slots).
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && result_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      skid_full_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      n_q         <= n_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      skid_full_q <= skid_full_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: selector, forwarding, skid backpressure, flush,
// reserved-code counting and mid-operation reset.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  si;
  logic [31:0] pb, hi, lo, pc;
  logic [15:0] imm;
  logic [4:0]  rt_addr;
  logic        fwd_ex_en, fwd_mem_en;
  logic [4:0]  fwd_ex_addr, fwd_mem_addr;
  logic [31:0] fwd_ex_data, fwd_mem_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] n;
  logic        err;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  operand_stage #(.W(32), .IMM_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .si(si),
    .pb(pb), .hi(hi), .lo(lo), .pc(pc), .imm(imm), .rt_addr(rt_addr),
    .fwd_ex_en(fwd_ex_en), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .n(n), .err(err),
    .err_cnt(err_cnt)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; si = 3'd0; pb = '0; hi = '0; lo = '0; pc = '0; imm = '0;
    rt_addr = 5'd3; fwd_ex_en = 1'b0; fwd_mem_en = 1'b0; fwd_ex_addr = '0; fwd_mem_addr = '0;
    fwd_ex_data = '0; fwd_mem_data = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if ({out_valid, in_ready, n, err, err_cnt} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h0}) begin
      miscompares++;
      $display("FAIL reset: ov=%b ir=%b n=%h err=%b cnt=%0d, want ov=0 ir=1 n=0 err=0 cnt=0",
               out_valid, in_ready, n, err, err_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_selector();
    logic [31:0] exp [7];
    exp[0] = 32'h4394AD13; exp[1] = 32'hA92FCFDF; exp[2] = 32'h714444A7;
    exp[3] = 32'h07A1BAEF; exp[4] = 32'hFFFF8001; exp[5] = 32'h00008001;
    exp[6] = 32'h80010000;
    pb = 32'h4394AD13; hi = 32'hA92FCFDF; lo = 32'h714444A7; pc = 32'h07A1BAE7;
    imm = 16'h8001; rt_addr = 5'd3; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      si = 3'(i); in_valid = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || n !== exp[i] || err !== 1'b0) begin
        miscompares++;
        $display("FAIL sel_%0d: ov=%b n=%h err=%b, want ov=1 n=%h err=0",
                 i, out_valid, n, err, exp[i]);
      end
    end
    si = 3'b110; imm = 16'h6C44;
    tick();
    vectors++;
    if (n !== 32'h6C440000) begin
      miscompares++;
      $display("FAIL sel_upper2: n=%h want 6c440000", n);
    end
    si = 3'b011; pc = 32'hFFFFFFFC;
    tick();
    vectors++;
    if (n !== 32'h00000004) begin
      miscompares++;
      $display("FAIL sel_pc_wrap: n=%h want 00000004", n);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL sel_idle: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp [4];
    exp[0] = 32'h11111111; exp[1] = 32'h22222222; exp[2] = 32'h22222222; exp[3] = 32'h0;
    si = 3'd0; pb = 32'h33333333; out_ready = 1'b1;
    fwd_ex_data = 32'h11111111; fwd_mem_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      rt_addr = 5'd5; fwd_ex_en = 1'b1; fwd_mem_en = 1'b1;
      fwd_ex_addr = 5'd5; fwd_mem_addr = 5'd5;
      if (i == 1) fwd_ex_en = 1'b0;
      if (i == 2) fwd_ex_addr = 5'd6;
      if (i == 3) begin rt_addr = 5'd0; fwd_ex_addr = 5'd0; fwd_mem_addr = 5'd0; end
      in_valid = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || n !== exp[i]) begin
        miscompares++;
        $display("FAIL fwd_%0d: ov=%b n=%h, want ov=1 n=%h", i, out_valid, n, exp[i]);
      end
    end
    in_valid = 1'b0; fwd_ex_en = 1'b0; fwd_mem_en = 1'b0; rt_addr = 5'd3;
    tick();
  endtask

  task automatic test_backpressure();
    si = 3'd0; rt_addr = 5'd3; out_ready = 1'b0;
    pb = 32'hAAAA0001; in_valid = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || n !== 32'hAAAA0001 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_a: ov=%b n=%h ir=%b, want 1 aaaa0001 1", out_valid, n, in_ready);
    end
    pb = 32'hBBBB0002;
    tick();
    vectors++;
    if (n !== 32'hAAAA0001 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_b: n=%h ir=%b, want aaaa0001 0", n, in_ready);
    end
    pb = 32'hCCCC0003;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || n !== 32'hAAAA0001 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_hold: ov=%b n=%h ir=%b, want 1 aaaa0001 0", out_valid, n, in_ready);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || n !== 32'hBBBB0002 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain_b: ov=%b n=%h ir=%b, want 1 bbbb0002 1", out_valid, n, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || n !== 32'hCCCC0003) begin
      miscompares++;
      $display("FAIL bp_drain_c: ov=%b n=%h, want 1 cccc0003", out_valid, n);
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_empty: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    si = 3'd0; out_ready = 1'b0; in_valid = 1'b1;
    pb = 32'h0F0F0001; tick();
    pb = 32'h0F0F0002; tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_fill: ir=%b ov=%b, want 0 1", in_ready, out_valid);
    end
    pb = 32'h0F0F0003; flush = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_clear: ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ghost: ov=%b n=%h, want ov=0", out_valid, n);
    end
  endtask

  task automatic test_reserved();
    out_ready = 1'b1; si = 3'b111; in_valid = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || n !== 32'h0 || err !== 1'b1 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL rsv_first: ov=%b n=%h err=%b cnt=%0d, want 1 0 1 1",
               out_valid, n, err, err_cnt);
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (err_cnt !== 8'd1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsv_flushed: cnt=%0d ov=%b, want 1 0", err_cnt, out_valid);
    end
    flush = 1'b0; si = 3'b001; hi = 32'h12345678;
    tick();
    vectors++;
    if (err !== 1'b0 || n !== 32'h12345678 || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL rsv_clean: err=%b n=%h cnt=%0d, want 0 12345678 1", err, n, err_cnt);
    end
    si = 3'b111;
    for (int i = 0; i < 300; i++) tick();
    vectors++;
    if (err_cnt !== 8'd255 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_saturate: cnt=%0d err=%b, want 255 1", err_cnt, err);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_midreset();
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b1; si = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (err_cnt !== 8'd7) begin
      miscompares++;
      $display("FAIL mr_cnt: cnt=%0d want 7", err_cnt);
    end
    out_ready = 1'b0; si = 3'd0; pb = 32'h55550001; tick();
    pb = 32'h55550002; tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, n, err, err_cnt} !== {1'b0, 1'b1, 32'h0, 1'b0, 8'h0}) begin
      miscompares++;
      $display("FAIL mr_reset: ov=%b ir=%b n=%h err=%b cnt=%0d, want 0 1 0 0 0",
               out_valid, in_ready, n, err, err_cnt);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mr_discard: ov=%b n=%h, want ov=0", out_valid, n);
    end
  endtask

  initial begin
    test_reset();
    test_selector();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_reserved();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
